// File: rtl/mx4_sel_pkg.sv
// Select-code constants shared by the 4-to-1 selector and the shifter datapath.
package mx4_sel_pkg;

  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_D0 = 2'b00;
  localparam logic [SEL_W-1:0] SEL_D1 = 2'b01;
  localparam logic [SEL_W-1:0] SEL_D2 = 2'b10;
  localparam logic [SEL_W-1:0] SEL_D3 = 2'b11;

endpackage

// File: rtl/mx4_sel.sv
// 4-to-1 selector: combinational output y plus a flopped copy y_q.
module mx4_sel
  import mx4_sel_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q
);

  logic [WIDTH-1:0] y_d;

  // Unknown select codes fall to zero so the mux can never hold state.
  function automatic logic [WIDTH-1:0] mux4_f(
    input logic [SEL_W-1:0] sel,
    input logic [WIDTH-1:0] a0,
    input logic [WIDTH-1:0] a1,
    input logic [WIDTH-1:0] a2,
    input logic [WIDTH-1:0] a3
  );
    logic [WIDTH-1:0] r;
    r = '0;
    case (sel)
      SEL_D0:  r = a0;
      SEL_D1:  r = a1;
      SEL_D2:  r = a2;
      SEL_D3:  r = a3;
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    y   = mux4_f(s, d0, d1, d2, d3);
    y_d = y;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

endmodule

// File: tb/tb_mx4_sel.sv
// Scoreboard bench for mx4_sel: stimulus queues expectations, a negedge monitor checks them.
module tb_mx4_sel;

  logic       clk;
  logic       reset;
  logic [1:0] s;
  logic       a0, a1, a2, a3;
  logic       y1, y1_q;
  logic [7:0] w0, w1, w2, w3;
  logic [7:0] y8, y8_q;

  int n_cmp;
  int n_bad;

  typedef struct {
    string      name;
    bit         wide;
    bit         regd;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];

  mx4_sel #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .s(s),
    .d0(a0), .d1(a1), .d2(a2), .d3(a3),
    .y(y1), .y_q(y1_q)
  );

  mx4_sel #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .s(s),
    .d0(w0), .d1(w1), .d2(w2), .d3(w3),
    .y(y8), .y_q(y8_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_v(input string name, input bit wide, input bit regd,
                          input logic [7:0] exp);
    exp_t e;
    e.name = name;
    e.wide = wide;
    e.regd = regd;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Apply a 1-bit vector just after a rising edge and queue the expected y.
  task automatic vec1(input string name, input logic [1:0] sel,
                      input logic v3, input logic v2, input logic v1,
                      input logic v0, input logic exp);
    @(posedge clk);
    #1;
    s  = sel;
    a3 = v3;
    a2 = v2;
    a1 = v1;
    a0 = v0;
    expect_v(name, 1'b0, 1'b0, {7'b0, exp});
  endtask

  // Monitor: outputs are settled by the falling edge.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.wide) act = e.regd ? y8_q : y8;
        else        act = e.regd ? {7'b0, y1_q} : {7'b0, y1};
        n_cmp++;
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    logic [3:0] hot;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    s     = 2'b00;
    {a3, a2, a1, a0} = 4'b0000;
    {w3, w2, w1, w0} = '0;
    expect_v("reset_yq1", 1'b0, 1'b1, 8'h00);
    expect_v("reset_yq8", 1'b1, 1'b1, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;

    vec1("all_zero",     2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vec1("sel_d1_zero",  2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    vec1("sel_d2_one",   2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    vec1("d0_drop_held", 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    vec1("sel_d3_one",   2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    vec1("sel_d1_one",   2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    vec1("d1_d3_clear",  2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vec1("sel_d3_again", 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    for (int h = 0; h < 4; h++) begin
      for (int k = 0; k < 4; k++) begin
        hot = 4'b0001 << h;
        vec1($sformatf("onehot_h%0d_s%0d", h, k), 2'(k),
             hot[3], hot[2], hot[1], hot[0], (h == k));
      end
    end

    // Wide instance shares s; its data words are distinct per input.
    @(posedge clk);
    #1;
    w0 = 8'h11;
    w1 = 8'h22;
    w2 = 8'h44;
    w3 = 8'h88;
    s  = 2'b00;
    expect_v("wide_s0", 1'b1, 1'b0, 8'h11);
    @(posedge clk); #1; s = 2'b01; expect_v("wide_s1", 1'b1, 1'b0, 8'h22);
    @(posedge clk); #1; s = 2'b10; expect_v("wide_s2", 1'b1, 1'b0, 8'h44);
    @(posedge clk); #1; s = 2'b11; expect_v("wide_s3", 1'b1, 1'b0, 8'h88);
    @(posedge clk); #1; expect_v("wide_yq_s3", 1'b1, 1'b1, 8'h88);

    // Register path: load a 1, then reset mid-cycle and recover.
    vec1("pre_rst_y", 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    expect_v("pre_rst_yq", 1'b0, 1'b1, 8'h01);
    @(posedge clk);
    #1;
    reset = 1'b1;
    expect_v("mid_rst_yq1", 1'b0, 1'b1, 8'h00);
    expect_v("mid_rst_yq8", 1'b1, 1'b1, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    s  = 2'b10;
    a2 = 1'b1;
    expect_v("rel_hold_yq", 1'b0, 1'b1, 8'h00);
    @(posedge clk);
    #1;
    expect_v("load_d2_yq", 1'b0, 1'b1, 8'h01);
    s  = 2'b00;
    a0 = 1'b0;
    @(posedge clk);
    #1;
    expect_v("load_d0_yq", 1'b0, 1'b1, 8'h00);

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
